unsolved_replay_scheduler: RTL and testbench
============================================

UNSOLVED_REPLAY_SCHEDULER -- requirements
Module: unsolved_replay_scheduler

Interface
REQ-001 SHALL provide parameters: DEPTH 16, FIFO entries, power of two; DEPTH_LOG 4, log2(DEPTH); ALMOST_FULL 12, stop threshold; HOLDOFF 4, replay delay cycles, >=1.
REQ-002 SHALL provide ports: clk input 1, single clock, all state on rising edge.
REQ-003 SHALL provide ports: rst_n input 1, reset, asynchronous, active-low.
REQ-004 SHALL provide ports: unsolved_wr_in input 1, unsolved token push strobe from BRAM stage.
REQ-005 SHALL provide ports: unsolved_data_in input 33, token [32:24] address, [23:16] byte valid, [15:0] offset.
REQ-006 SHALL provide ports: unsolved_rd_in input 1, pop strobe, driven by the selector's unsolved read.
REQ-007 SHALL provide ports: flush_in input 1, synchronous clear at block boundary.
REQ-008 SHALL provide ports: unsolved_out output 33, head token, first-word fall-through.
REQ-009 SHALL provide ports: unsolved_valid_out output 1, head token offered to selector.
REQ-010 SHALL provide ports: stop_out output 1, backpressure to selector/parsers.
REQ-011 SHALL provide ports: empty_out output 1, no pending unsolved tokens.
REQ-012 SHALL provide ports: overflow_out output 1, sticky push-while-full error.

Function
REQ-013 SHALL hold a count register 0..DEPTH; push writes mem[wr_ptr] and increments wr_ptr modulo DEPTH; pop increments rd_ptr modulo DEPTH.
REQ-014 SHALL accept a pop only when unsolved_rd_in & unsolved_valid_out; pop otherwise ignored.
REQ-015 SHALL keep count unchanged on simultaneous accepted push and pop, including at count==DEPTH (pop frees slot same cycle).
REQ-016 SHALL drop a push when count==DEPTH without simultaneous pop, and set overflow_out next cycle, held until reset.
REQ-017 SHALL implement FSM IDLE, HOLD, REPLAY; IDLE->HOLD on push, loading hold counter with HOLDOFF.
REQ-018 SHALL in HOLD decrement the counter each cycle; at counter==1 go to REPLAY; any push in HOLD reloads HOLDOFF.
REQ-019 SHALL drive unsolved_valid_out = (state==REPLAY) & (count!=0), from registers only.
REQ-020 SHALL in REPLAY go to IDLE when an accepted pop empties the FIFO with no push that cycle; otherwise stay.
REQ-021 SHALL therefore assert unsolved_valid_out first HOLDOFF+1 cycles after a push into an idle empty FIFO.
REQ-022 SHALL drive unsolved_out = mem[rd_ptr] combinationally; value undefined when unsolved_valid_out low.
REQ-023 SHALL drive stop_out = (count >= ALMOST_FULL), empty_out = (count==0).
REQ-024 SHALL on flush_in clear pointers, count and hold counter and enter IDLE next cycle; flush wins over simultaneous push/pop; overflow_out unaffected.

Reset
REQ-025 SHALL on rst_n low asynchronously set state IDLE, pointers 0, count 0, hold counter 0, overflow_out 0; outputs: unsolved_valid_out 0, stop_out 0, empty_out 1; memory contents not reset.
REQ-026 SHALL recover cleanly from reset asserted mid-REPLAY: first post-reset cycle behaves as empty IDLE.

Configuration
REQ-027 SHALL, with UNSOLVED_REPLAY_STATS_EN defined, add output replay_cnt_out 32 counting accepted pops and output max_level_out DEPTH_LOG+1 holding peak count, both reset to 0, cleared by flush_in, replay_cnt_out saturating at all-ones.
REQ-028 SHALL, without UNSOLVED_REPLAY_STATS_EN, omit both ports and their logic; all other behaviour identical.

Structure
REQ-029 SHALL place in the shared decompressor package: token width 33, field positions (address [32:24], byte valid [23:16], offset [15:0]), FSM state enumeration.
REQ-030 SHALL isolate storage in one sub-module unsolved_ram (DEPTH x 33, one write port, asynchronous read port); pointers, count and FSM stay in the top.

Verification
REQ-031 SHALL cover: push token 0x1_2345_6789 at cycle 0 into empty -> unsolved_valid_out rises cycle 5, unsolved_out 0x1_2345_6789, pop -> empty_out 1, state IDLE.
REQ-032 SHALL cover: 12 pushes back-to-back -> stop_out high the cycle after 12th push; one pop -> stop_out low next cycle.
REQ-033 SHALL cover: fill to 16, push+pop same cycle -> count stays 16, no overflow; lone 17th push -> overflow_out 1, data of entry 0 still head.
REQ-034 SHALL cover: push at cycles 0 and 2 -> hold reload, valid rises cycle 7; pops return tokens in push order.
REQ-035 SHALL cover: flush_in with count 5 and simultaneous push -> next cycle count 0, empty_out 1, valid 0; rst_n pulse mid-REPLAY -> outputs at reset values immediately.

Source files
------------

// File: rtl/unsolved_replay_scheduler_pkg.sv
// unsolved_replay_scheduler_pkg: token layout and replay FSM states shared by the scheduler slice.
package unsolved_replay_scheduler_pkg;
  localparam int TOKEN_W = 33;
  localparam int ADDR_HI = 32;
  localparam int ADDR_LO = 24;
  localparam int BV_HI   = 23;
  localparam int BV_LO   = 16;
  localparam int OFF_HI  = 15;
  localparam int OFF_LO  = 0;
  typedef logic [TOKEN_W-1:0] token_t;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPLAY} state_t;
endpackage

// File: rtl/unsolved_replay_scheduler_if.sv
// unsolved_replay_scheduler_if: push/pop/status bundle between the BRAM stage, selector and scheduler.
interface unsolved_replay_scheduler_if;
  import unsolved_replay_scheduler_pkg::*;
  logic   unsolved_wr_in;
  token_t unsolved_data_in;
  logic   unsolved_rd_in;
  logic   flush_in;
  token_t unsolved_out;
  logic   unsolved_valid_out;
  logic   stop_out;
  logic   empty_out;
  logic   overflow_out;
  modport master (
    output unsolved_wr_in, unsolved_data_in, unsolved_rd_in, flush_in,
    input  unsolved_out, unsolved_valid_out, stop_out, empty_out, overflow_out
  );
  modport slave (
    input  unsolved_wr_in, unsolved_data_in, unsolved_rd_in, flush_in,
    output unsolved_out, unsolved_valid_out, stop_out, empty_out, overflow_out
  );
endinterface

// File: rtl/unsolved_replay_scheduler_ram.sv
// unsolved_ram: token storage, one write port and an asynchronous read port; contents are never reset.
module unsolved_ram
  import unsolved_replay_scheduler_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [DEPTH_LOG-1:0] i_wa,
  input  token_t               i_wd,
  input  logic [DEPTH_LOG-1:0] i_ra,
  output token_t               o_rd
);
  token_t r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_wa] <= i_wd;
  assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/unsolved_replay_scheduler.sv
// unsolved_replay_scheduler: FIFO of unsolved tokens replayed after a holdoff; define
// UNSOLVED_REPLAY_STATS_EN to add replay_cnt_out / max_level_out statistics.
module unsolved_replay_scheduler
  import unsolved_replay_scheduler_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DEPTH_LOG   = 4,
  parameter int ALMOST_FULL = 12,
  parameter int HOLDOFF     = 4
) (
  input  logic clk,
  input  logic rst_n,
  unsolved_replay_scheduler_if.slave bus
`ifdef UNSOLVED_REPLAY_STATS_EN
  ,
  output logic [31:0]        replay_cnt_out,
  output logic [DEPTH_LOG:0] max_level_out
`endif
);
  localparam int CW = DEPTH_LOG + 1;
  localparam int HW = $clog2(HOLDOFF + 1);
  state_t               r_state;
  logic [HW-1:0]        r_hold;
  logic [DEPTH_LOG-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic                 w_full, w_valid, w_pop, w_push, w_wr, w_flush;
  logic [CW-1:0]        w_count_nxt;
  assign w_wr        = bus.unsolved_wr_in;
  assign w_flush     = bus.flush_in;
  assign w_full      = r_count == CW'(DEPTH);
  assign w_valid     = (r_state == S_REPLAY) && (r_count != '0);
  assign w_pop       = bus.unsolved_rd_in & w_valid;
  // a pop frees its slot in the same cycle, so a full FIFO still takes a push alongside it
  assign w_push      = w_wr & (~w_full | w_pop);
  assign w_count_nxt = w_flush ? '0 : r_count + CW'(w_push) - CW'(w_pop);
  assign bus.unsolved_valid_out = w_valid;
  assign bus.stop_out           = r_count >= CW'(ALMOST_FULL);
  assign bus.empty_out          = r_count == '0;
  assign bus.overflow_out       = r_ovf;
  unsolved_ram #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) u_ram (
    .clk  (clk),
    .i_we (w_push & ~w_flush),
    .i_wa (r_wr_ptr),
    .i_wd (bus.unsolved_data_in),
    .i_ra (r_rd_ptr),
    .o_rd (bus.unsolved_out)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_flush ? '0 : r_wr_ptr + DEPTH_LOG'(w_push);
      r_rd_ptr <= w_flush ? '0 : r_rd_ptr + DEPTH_LOG'(w_pop);
      r_count  <= w_count_nxt;
      r_ovf    <= r_ovf | (w_wr & w_full & ~w_pop & ~w_flush);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else if (w_flush) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_wr) begin
          r_state <= S_HOLD;
          r_hold  <= HW'(HOLDOFF);
        end
        S_HOLD: begin
          r_hold <= w_wr ? HW'(HOLDOFF) : r_hold - 1'b1;
          if (!w_wr && r_hold == HW'(1)) r_state <= S_REPLAY;
        end
        S_REPLAY: if (w_pop && r_count == CW'(1) && !w_wr) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
`ifdef UNSOLVED_REPLAY_STATS_EN
  logic [31:0] r_replay_cnt;
  logic [CW-1:0] r_max_level;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_replay_cnt <= '0;
      r_max_level  <= '0;
    end else begin
      r_replay_cnt <= w_flush ? '0 : r_replay_cnt + 32'(w_pop & ~&r_replay_cnt);
      r_max_level  <= w_flush ? '0 : (w_count_nxt > r_max_level ? w_count_nxt : r_max_level);
    end
  assign replay_cnt_out = r_replay_cnt;
  assign max_level_out  = r_max_level;
`endif
endmodule

// File: tb/tb_unsolved_replay_scheduler.sv
// tb_unsolved_replay_scheduler: directed scenarios plus random traffic checked against a queue model.
module tb_unsolved_replay_scheduler;
  import unsolved_replay_scheduler_pkg::*;
  localparam int DEPTH = 16, DEPTH_LOG = 4, AF = 12, HOLDOFF = 4;
  logic clk = 1'b0, rst_n;
  int n_vec = 0, n_err = 0, cyc = 0, armed_at = 0, t0;
  bit armed = 0, ovf = 0;
  token_t q[$];
  unsolved_replay_scheduler_if bus();
`ifdef UNSOLVED_REPLAY_STATS_EN
  logic [31:0] replay_cnt;
  logic [DEPTH_LOG:0] max_level;
`endif
  unsolved_replay_scheduler #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .ALMOST_FULL(AF), .HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UNSOLVED_REPLAY_STATS_EN
    , .replay_cnt_out(replay_cnt), .max_level_out(max_level)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic token_t rnd_tok();
    return token_t'({1'($urandom), 32'($urandom)});
  endfunction
  // one clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic wr, input token_t d, input logic rd, input logic fl);
    bit rep, pop;
    int n;
    bus.unsolved_wr_in = wr; bus.unsolved_data_in = d; bus.unsolved_rd_in = rd; bus.flush_in = fl;
    #4;
    rep = armed && cyc >= armed_at;
    n = q.size();
    chk("valid", bus.unsolved_valid_out, rep && n > 0);
    chk("empty", bus.empty_out, n == 0);
    chk("stop", bus.stop_out, n >= AF);
    chk("overflow", bus.overflow_out, ovf);
    if (rep && n > 0) chk("head", bus.unsolved_out, q[0]);
    if (fl) begin
      q.delete();
      armed = 0;
    end else begin
      pop = rd && rep && n > 0;
      if (wr && n == DEPTH && !pop) ovf = 1;
      if (pop) void'(q.pop_front());
      if (wr && (n < DEPTH || pop)) q.push_back(d);
      if (!rep) begin
        if (wr) begin armed = 1; armed_at = cyc + HOLDOFF + 1; end
      end else if (pop && n == 1 && !wr) armed = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 40 && !bus.unsolved_valid_out; i++) idle(1);
  endtask
  task automatic rst_pulse();
    bus.unsolved_wr_in = 0; bus.unsolved_rd_in = 0; bus.flush_in = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.unsolved_valid_out, 0);
    chk("rst_empty", bus.empty_out, 1);
    chk("rst_stop", bus.stop_out, 0);
    chk("rst_overflow", bus.overflow_out, 0);
    q.delete(); armed = 0; ovf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
  endtask
  initial begin
    token_t a, b;
    bus.unsolved_wr_in = 0; bus.unsolved_data_in = '0; bus.unsolved_rd_in = 0; bus.flush_in = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_pulse();
    // single token into an idle FIFO: valid after HOLDOFF+1 cycles
    t0 = cyc;
    step(1, 33'h1_2345_6789, 0, 0);
    wait_valid();
    chk("latency1", 33'(cyc - t0), 33'd5);
    chk("token1", bus.unsolved_out, 33'h1_2345_6789);
    step(0, '0, 1, 0);
    chk("empty_after_pop", bus.empty_out, 1);
    idle(2);
    // almost-full threshold
    for (int i = 0; i < 12; i++) step(1, rnd_tok(), 0, 0);
    chk("stop_at12", bus.stop_out, 1);
    wait_valid();
    step(0, '0, 1, 0);
    chk("stop_after_pop", bus.stop_out, 0);
    step(0, '0, 0, 1);
    // full FIFO: lone push overflows, head unchanged, then push+pop at full
    a = rnd_tok();
    step(1, a, 0, 0);
    for (int i = 1; i < 16; i++) step(1, rnd_tok(), 0, 0);
    step(1, rnd_tok(), 0, 0);
    chk("ovf_set", bus.overflow_out, 1);
    wait_valid();
    chk("head_entry0", bus.unsolved_out, a);
    step(1, rnd_tok(), 1, 0);
    chk("full_pushpop_empty", bus.empty_out, 0);
    chk("full_pushpop_stop", bus.stop_out, 1);
    for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
    chk("drained", bus.empty_out, 1);
    step(0, '0, 0, 1);
    chk("flush_keeps_ovf", bus.overflow_out, 1);
    // holdoff reload: pushes at relative cycles 0 and 2
    a = rnd_tok(); b = rnd_tok();
    t0 = cyc;
    step(1, a, 0, 0);
    idle(1);
    step(1, b, 0, 0);
    wait_valid();
    chk("latency_reload", 33'(cyc - t0), 33'd7);
    step(0, '0, 1, 0);
    chk("order2", bus.unsolved_out, b);
    step(0, '0, 1, 0);
    // flush beats a simultaneous push
    for (int i = 0; i < 5; i++) step(1, rnd_tok(), 0, 0);
    step(1, rnd_tok(), 0, 1);
    chk("flush_empty", bus.empty_out, 1);
    chk("flush_valid", bus.unsolved_valid_out, 0);
    // reset mid-replay
    for (int i = 0; i < 3; i++) step(1, rnd_tok(), 0, 0);
    wait_valid();
    step(0, '0, 1, 0);
    rst_pulse();
    idle(2);
    // random traffic in three biases: filling, draining, balanced
    for (int ph = 0; ph < 3; ph++)
      for (int i = 0; i < 1000; i++) begin
        int wp = (ph == 0) ? 70 : (ph == 1) ? 25 : 50;
        int rp = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
        step(32'($urandom_range(99)) < wp, rnd_tok(), 32'($urandom_range(99)) < rp,
             $urandom_range(127) == 0);
      end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
